// File: rtl/matrix_m1_responder.sv
`default_nettype none
// ============================================================================
// Module  : matrix_m1_responder
// Brief   : M1 bus responder with result RAM, write counter and host read port.
// Revision: 1.0 - initial release
// ============================================================================
module matrix_m1_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int GRANT_LAT = 1,
    parameter int EXP_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              M1_req,
    input  logic              M1_wr,
    input  logic [ADDR_W-1:0] M1_address,
    input  logic [DATA_W-1:0] M1_dout,
    output logic              M1_grant,
    output logic [DATA_W-1:0] M_din,
    output logic              M_din_valid,
    input  logic              h_rd_en,
    input  logic [ADDR_W-1:0] h_addr,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              h_clr,
    output logic [ADDR_W:0]   wr_count,
    output logic              sink_done
);

    localparam int              c_DEPTH  = 1 << ADDR_W;
    localparam int              c_LAT    = GRANT_LAT - 1;
    localparam logic [2:0]      c_LAT_M1 = c_LAT[2:0];
    localparam logic [ADDR_W:0] c_MAX    = c_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_EXP    = EXP_WORDS[ADDR_W:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GRANT = 2'd2,
        S_REL   = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_lat;
    logic              r_grant;
    logic [DATA_W-1:0] r_din;
    logic              r_din_valid;
    logic [DATA_W-1:0] r_hrdata;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic w_acc_wr;
    logic w_acc_rd;

    // A clear in the same cycle discards the transfer.
    assign w_acc_wr = r_grant & M1_req &  M1_wr & ~h_clr;
    assign w_acc_rd = r_grant & M1_req & ~M1_wr & ~h_clr;

    always_ff @(posedge clk) begin
        if (w_acc_wr) begin
            r_mem[M1_address] <= M1_dout;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_lat       <= 3'd0;
            r_grant     <= 1'b0;
            r_din       <= '0;
            r_din_valid <= 1'b0;
            r_hrdata    <= '0;
            r_cnt       <= '0;
        end else begin
            if (h_rd_en) begin
                r_hrdata <= r_mem[h_addr];
            end
            if (h_clr) begin
                r_state     <= S_IDLE;
                r_grant     <= 1'b0;
                r_din_valid <= 1'b0;
                r_cnt       <= '0;
            end else begin
                r_din_valid <= w_acc_rd;
                if (w_acc_rd) begin
                    r_din <= r_mem[M1_address];
                end
                if (w_acc_wr && (r_cnt != c_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                case (r_state)
                    S_IDLE: begin
                        r_grant <= 1'b0;
                        if (M1_req) begin
                            r_lat   <= c_LAT_M1;
                            r_state <= (GRANT_LAT == 1) ? S_GRANT : S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        r_grant <= 1'b0;
                        if (!M1_req) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_lat <= r_lat - 3'd1;
                            if (r_lat == 3'd1) begin
                                r_state <= S_GRANT;
                            end
                        end
                    end
                    S_GRANT: begin
                        // Grant rises one edge after entering GRANT and falls on the edge req drops.
                        if (M1_req) begin
                            r_grant <= 1'b1;
                        end else begin
                            r_grant <= 1'b0;
                            r_state <= S_REL;
                        end
                    end
                    S_REL: begin
                        r_grant <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_grant <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign M1_grant    = r_grant;
    assign M_din       = r_din;
    assign M_din_valid = r_din_valid;
    assign h_rdata     = r_hrdata;
    assign wr_count    = r_cnt;
    assign sink_done   = (r_cnt >= c_EXP);

endmodule
`default_nettype wire

// File: tb/tb_matrix_m1_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_matrix_m1_responder
// Brief   : Self-checking bench: vector table, directed corner cases, random bursts.
// Revision: 1.0 - initial release
// ============================================================================
module tb_matrix_m1_responder;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req = 1'b0, wr = 1'b0, req3 = 1'b0, wr3 = 1'b0;
    logic [AW-1:0] addr = '0, haddr = '0;
    logic [DW-1:0] dout = '0;
    logic          hrd = 1'b0, hclr = 1'b0;

    logic          grant, dvalid, done, grant3, dvalid3, done3;
    logic [DW-1:0] din, hrdata, din3, hrdata3;
    logic [AW:0]   cnt, cnt3;

    always #5 clk = ~clk;

    matrix_m1_responder #(.ADDR_W(AW), .DATA_W(DW), .GRANT_LAT(1), .EXP_WORDS(16)) u_l1 (
        .clk(clk), .reset_n(reset_n), .M1_req(req), .M1_wr(wr), .M1_address(addr),
        .M1_dout(dout), .M1_grant(grant), .M_din(din), .M_din_valid(dvalid),
        .h_rd_en(hrd), .h_addr(haddr), .h_rdata(hrdata), .h_clr(hclr),
        .wr_count(cnt), .sink_done(done)
    );

    matrix_m1_responder #(.ADDR_W(AW), .DATA_W(DW), .GRANT_LAT(3), .EXP_WORDS(16)) u_l3 (
        .clk(clk), .reset_n(reset_n), .M1_req(req3), .M1_wr(wr3), .M1_address(addr),
        .M1_dout(dout), .M1_grant(grant3), .M_din(din3), .M_din_valid(dvalid3),
        .h_rd_en(hrd), .h_addr(haddr), .h_rdata(hrdata3), .h_clr(hclr),
        .wr_count(cnt3), .sink_done(done3)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          hrd;
        logic [AW-1:0] haddr;
        logic          ev;
        logic [DW-1:0] edin;
        logic [DW-1:0] eh;
        int            ecnt;
        logic          edone;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem [16];
    int            m_cnt;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_h;
    vec_t          tbl [20];

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic h, input logic [AW-1:0] ha, input logic ev,
                                input logic [DW-1:0] edin, input logic [DW-1:0] eh,
                                input int ecnt, input logic edone);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.hrd = h; v.haddr = ha;
        v.ev = ev; v.edin = edin; v.eh = eh; v.ecnt = ecnt; v.edone = edone;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i] = mk(1'b1, AW'(i), DW'(100 + i), 1'b0, '0, 1'b0, '0, '0, i + 1, (i == 15));
        end
        tbl[16] = mk(1'b0, 4'd3, '0,      1'b0, 4'd0, 1'b1, 32'd103, 32'd0,   16, 1'b1);
        tbl[17] = mk(1'b1, 4'd3, 32'hAA,  1'b1, 4'd3, 1'b0, '0,      32'd103, 16, 1'b1);
        tbl[18] = mk(1'b1, 4'd5, 32'h55,  1'b1, 4'd3, 1'b0, '0,      32'hAA,  16, 1'b1);
        tbl[19] = mk(1'b0, 4'd3, '0,      1'b0, 4'd0, 1'b1, 32'hAA,  32'hAA,  16, 1'b1);
        m_cnt = 0;

        // Reset state
        tick();
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_valid", 64'(dvalid), 64'(0));
        chk("rst_din", 64'(din), 64'(0));
        chk("rst_hrdata", 64'(hrdata), 64'(0));
        chk("rst_cnt", 64'(cnt), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_grant3", 64'(grant3), 64'(0));
        chk("rst_din3", 64'(din3), 64'(0));
        reset_n = 1'b1;

        // Grant timing with GRANT_LAT=1, drop and re-grant gap
        req = 1'b1; wr = 1'b0; addr = '0;
        tick(); chk("t1_e0_grant", 64'(grant), 64'(0));
        tick(); chk("t1_e1_grant", 64'(grant), 64'(1)); chk("t1_e1_valid", 64'(dvalid), 64'(0));
        tick(); chk("t1_e2_valid", 64'(dvalid), 64'(1));
        tick(); tick(); chk("t1_e4_grant", 64'(grant), 64'(1));
        req = 1'b0;
        tick(); chk("t1_e5_grant", 64'(grant), 64'(0)); chk("t1_e5_valid", 64'(dvalid), 64'(0));
        req = 1'b1;
        tick(); chk("t1_e6_grant", 64'(grant), 64'(0));
        tick(); chk("t1_e7_grant", 64'(grant), 64'(0));
        tick(); chk("t1_e8_grant", 64'(grant), 64'(1));

        // Table-driven burst: writes, reads and read-before-write
        for (int i = 0; i < 20; i++) begin
            wr = tbl[i].wr; addr = tbl[i].addr; dout = tbl[i].data;
            hrd = tbl[i].hrd; haddr = tbl[i].haddr;
            tick();
            chk($sformatf("tbl%0d_valid", i), 64'(dvalid), 64'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_din", i), 64'(din), 64'(tbl[i].edin));
            chk($sformatf("tbl%0d_hrdata", i), 64'(hrdata), 64'(tbl[i].eh));
            chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].edone));
            chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(1));
            if (tbl[i].wr) m_mem[tbl[i].addr] = tbl[i].data;
        end
        hrd = 1'b0; req = 1'b0; wr = 1'b0;
        tick(); chk("burst_end_grant", 64'(grant), 64'(0));
        tick();

        for (int i = 0; i < 16; i++) begin
            haddr = AW'(i); hrd = 1'b1;
            tick(); chk($sformatf("host_rd%0d", i), 64'(hrdata), 64'(m_mem[i]));
        end
        hrd = 1'b0;

        // Clear coincident with a write to addr 7
        addr = 4'd7; dout = 32'h777; wr = 1'b1; req = 1'b1;
        tick(); tick(); chk("t5_grant_pre", 64'(grant), 64'(1)); chk("t5_cnt_pre", 64'(cnt), 64'(16));
        hclr = 1'b1;
        tick(); hclr = 1'b0; req = 1'b0;
        chk("t5_cnt", 64'(cnt), 64'(0)); chk("t5_done", 64'(done), 64'(0)); chk("t5_grant", 64'(grant), 64'(0));
        tick(); tick();
        haddr = 4'd7; hrd = 1'b1;
        tick(); hrd = 1'b0;
        chk("t5_ram7", 64'(hrdata), 64'(m_mem[7]));

        // GRANT_LAT=3: requests during WAIT are ignored
        addr = 4'd2; dout = 32'h1111; wr3 = 1'b1; req3 = 1'b1;
        tick(); chk("t4_e0_grant", 64'(grant3), 64'(0));
        tick(); chk("t4_e1_grant", 64'(grant3), 64'(0));
        tick(); chk("t4_e2_grant", 64'(grant3), 64'(0));
        tick(); chk("t4_e3_grant", 64'(grant3), 64'(1)); chk("t4_e3_cnt", 64'(cnt3), 64'(0));
        addr = 4'd9; dout = 32'h2222;
        tick(); chk("t4_e4_cnt", 64'(cnt3), 64'(1)); chk("t4_valid", 64'(dvalid3), 64'(0));
        chk("t4_done", 64'(done3), 64'(0));
        req3 = 1'b0;
        tick(); chk("t4_drop_grant", 64'(grant3), 64'(0));
        tick();
        haddr = 4'd9; hrd = 1'b1;
        tick(); hrd = 1'b0;
        chk("t4_ram9", 64'(hrdata3), 64'(32'h2222));
        // Request withdrawn during WAIT restarts the latency
        req3 = 1'b1; tick(); req3 = 1'b0; tick(); tick();
        chk("t4_abort_grant", 64'(grant3), 64'(0));
        req3 = 1'b1;
        tick(); tick(); tick(); chk("t4_rearm_e2", 64'(grant3), 64'(0));
        tick(); chk("t4_rearm_e3", 64'(grant3), 64'(1));
        req3 = 1'b0; wr3 = 1'b0;
        tick(); tick();

        // Asynchronous reset mid-burst
        req = 1'b1; wr = 1'b0; addr = 4'd1;
        tick(); tick(); tick();
        chk("t6_pre_grant", 64'(grant), 64'(1));
        #3 reset_n = 1'b0;
        #1;
        chk("t6_grant", 64'(grant), 64'(0));
        chk("t6_valid", 64'(dvalid), 64'(0));
        chk("t6_din", 64'(din), 64'(0));
        chk("t6_hrdata", 64'(hrdata), 64'(0));
        chk("t6_cnt", 64'(cnt), 64'(0));
        chk("t6_done", 64'(done), 64'(0));
        req = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        req = 1'b1;
        tick(); chk("t6_post_e0", 64'(grant), 64'(0));
        tick(); chk("t6_post_e1", 64'(grant), 64'(1));
        req = 1'b0;
        tick(); tick();

        // Random bursts against the reference model
        m_cnt = 0; m_din = '0; m_h = '0;
        for (int b = 0; b < 20; b++) begin
            int len;
            len = $urandom_range(1, 8);
            req = 1'b1; wr = 1'($urandom_range(0, 1));
            addr = AW'($urandom_range(0, 15)); dout = $urandom;
            tick(); chk("rnd_lat_e0", 64'(grant), 64'(0));
            tick(); chk("rnd_lat_e1", 64'(grant), 64'(1)); chk("rnd_lat_cnt", 64'(cnt), 64'(m_cnt));
            for (int k = 0; k < len; k++) begin
                logic ev;
                wr = 1'($urandom_range(0, 1)); addr = AW'($urandom_range(0, 15)); dout = $urandom;
                hrd = 1'($urandom_range(0, 1)); haddr = AW'($urandom_range(0, 15));
                ev = !wr;
                if (!wr) m_din = m_mem[addr];
                if (hrd) m_h = m_mem[haddr];
                if (wr) begin
                    m_mem[addr] = dout;
                    m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
                end
                tick();
                chk("rnd_valid", 64'(dvalid), 64'(ev));
                chk("rnd_din", 64'(din), 64'(m_din));
                chk("rnd_hrdata", 64'(hrdata), 64'(m_h));
                chk("rnd_cnt", 64'(cnt), 64'(m_cnt));
                chk("rnd_done", 64'(done), 64'(m_cnt >= 16));
                chk("rnd_grant", 64'(grant), 64'(1));
            end
            req = 1'b0; hrd = 1'b0;
            tick(); chk("rnd_drop_grant", 64'(grant), 64'(0)); chk("rnd_drop_valid", 64'(dvalid), 64'(0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
